// File: rtl/alarm_pkg.sv
// Shared constants for the alarm scanner: slot field layout, slot count and FSM state encoding.
package alarm_pkg;

    localparam int N_SLOTS   = 7;
    localparam int SLOT_W    = 13;
    localparam int ARMED_BIT = 12;
    localparam int HOUR_MSB  = 10;
    localparam int HOUR_LSB  = 6;
    localparam int MIN_MSB   = 5;
    localparam int MIN_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_RING   = 2'd2,
        ST_SNOOZE = 2'd3
    } state_t;

endpackage

// File: rtl/minute_counter.sv
// Saturating 4-bit minute-tick counter; o_hit flags the tick that reaches the terminal count.
module minute_counter #(
    parameter logic [3:0] TERM = 4'd5
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_tick,
    output logic o_hit
);

    logic [3:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= 4'd0;
        end else if (i_tick && (r_cnt != TERM)) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // TERM is at least 1, so TERM-1 never underflows.
    assign o_hit = i_tick && (r_cnt >= (TERM - 4'd1));

endmodule

// File: rtl/alarm_scanner.sv
// Scans the seven alarm slots on each minute tick and runs the ring / stop / snooze sequence.
// Build option: define ALARM_SNOOZE_EN to enable the SNOOZE state and the snooze input.
module alarm_scanner
    import alarm_pkg::*;
#(
    parameter logic [3:0] RING_MIN   = 4'd5,
    parameter logic [3:0] SNOOZE_MIN = 4'd9
) (
    input  logic        i_clock,
    input  logic        i_clear,
    input  logic [12:0] i_q_r0,
    input  logic [12:0] i_q_r1,
    input  logic [12:0] i_q_r2,
    input  logic [12:0] i_q_r3,
    input  logic [12:0] i_q_r4,
    input  logic [12:0] i_q_r5,
    input  logic [12:0] i_q_r6,
    input  logic [4:0]  i_cur_h,
    input  logic [5:0]  i_cur_m,
    input  logic        i_min_tick,
    input  logic        i_stop,
    input  logic        i_snooze,
    output logic        o_alarm,
    output logic [2:0]  o_active_slot,
    output logic        o_snoozing,
    output logic        o_scan_busy
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_idx;
    logic [2:0]          w_idx_nxt;
    logic [2:0]          r_active_slot;
    logic [2:0]          w_active_nxt;
    logic                r_alarm;
    logic                r_snoozing;
    logic                r_scan_busy;
    logic [SLOT_W-1:0]   w_slot;
    logic                w_match;
    logic                w_snooze_req;
    logic                w_ring_tick;
    logic                w_ring_hit;
    logic                w_snz_hit;
    logic                w_unused;

    // Slots are read live so a write landing ahead of the scan pointer is honoured.
    always_comb begin
        w_slot = '0;
        case (r_idx)
            3'd0:    w_slot = i_q_r0;
            3'd1:    w_slot = i_q_r1;
            3'd2:    w_slot = i_q_r2;
            3'd3:    w_slot = i_q_r3;
            3'd4:    w_slot = i_q_r4;
            3'd5:    w_slot = i_q_r5;
            3'd6:    w_slot = i_q_r6;
            default: w_slot = '0;
        endcase
    end

    assign w_match = w_slot[ARMED_BIT]
                  && (w_slot[HOUR_MSB:HOUR_LSB] == i_cur_h)
                  && (w_slot[MIN_MSB:MIN_LSB] == i_cur_m);

`ifdef ALARM_SNOOZE_EN
    logic w_snz_tick;

    assign w_snooze_req = i_snooze;
    assign w_snz_tick   = (r_state == ST_SNOOZE) && i_min_tick && !i_stop;

    minute_counter #(.TERM(SNOOZE_MIN)) u_snz_cnt (
        .i_clk  (i_clock),
        .i_rst  (i_clear),
        .i_clr  (r_state != ST_SNOOZE),
        .i_tick (w_snz_tick),
        .o_hit  (w_snz_hit)
    );
    assign w_unused = w_slot[11];
`else
    assign w_snooze_req = 1'b0;
    assign w_snz_hit    = 1'b0;
    assign w_unused     = ^{w_slot[11], i_snooze, w_snz_hit};
`endif

    assign w_ring_tick = (r_state == ST_RING) && i_min_tick && !i_stop && !w_snooze_req;

    minute_counter #(.TERM(RING_MIN)) u_ring_cnt (
        .i_clk  (i_clock),
        .i_rst  (i_clear),
        .i_clr  (r_state != ST_RING),
        .i_tick (w_ring_tick),
        .o_hit  (w_ring_hit)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_active_nxt = r_active_slot;
        case (r_state)
            ST_IDLE: begin
                if (i_min_tick) begin
                    w_state_nxt = ST_SCAN;
                    w_idx_nxt   = 3'd0;
                end
            end
            ST_SCAN: begin
                if (w_match) begin
                    w_state_nxt  = ST_RING;
                    w_active_nxt = r_idx;
                end else if (r_idx == 3'(N_SLOTS - 1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_idx_nxt = r_idx + 3'd1;
                end
            end
            ST_RING: begin
                if (i_stop)            w_state_nxt = ST_IDLE;
                else if (w_snooze_req) w_state_nxt = ST_SNOOZE;
                else if (w_ring_hit)   w_state_nxt = ST_IDLE;
            end
            ST_SNOOZE: begin
                if (i_stop)         w_state_nxt = ST_IDLE;
                else if (w_snz_hit) w_state_nxt = ST_RING;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_state       <= ST_IDLE;
            r_idx         <= 3'd0;
            r_active_slot <= 3'd0;
            r_alarm       <= 1'b0;
            r_snoozing    <= 1'b0;
            r_scan_busy   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_active_slot <= w_active_nxt;
            r_alarm       <= (w_state_nxt == ST_RING);
            r_snoozing    <= (w_state_nxt == ST_SNOOZE);
            r_scan_busy   <= (w_state_nxt == ST_SCAN);
        end
    end

    assign o_alarm       = r_alarm;
    assign o_active_slot = r_active_slot;
    assign o_snoozing    = r_snoozing;
    assign o_scan_busy   = r_scan_busy;

endmodule
